// File: rtl/ch_advert_tx.sv
`default_nettype none
// ============================================================================
// Module   : ch_advert_tx
// Purpose  : Cluster-head advertisement transmitter. Serializes a 4-word
//            advertisement (type, ID, hops, Q) onto a valid/ready word stream,
//            repeated a fixed number of times with idle gaps in between.
// Revision : 1.0 - initial release
// ============================================================================
module ch_advert_tx #(
  parameter int                    WORD_WIDTH   = 16,
  parameter logic [WORD_WIDTH-1:0] MSG_TYPE_CH  = 16'h0001,
  parameter logic [15:0]           ADV_INTERVAL = 16'd20,
  parameter logic [15:0]           ADV_REPEATS  = 16'd3
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en_CHadv,
  input  logic                  HB_reset,
  input  logic                  role_CH,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic [WORD_WIDTH-1:0] myQValue,
  input  logic [WORD_WIDTH-1:0] hopsFromCH,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic                  tx_busy,
  output logic                  adv_done
);

  // A repeat count of zero still sends the message once.
  localparam logic [16:0] C_REPS = (ADV_REPEATS == 16'd0) ? 17'd1 : {1'b0, ADV_REPEATS};
  localparam logic [WORD_WIDTH-1:0] C_ONE = 1;

  typedef enum logic [2:0] {
    s_idle = 3'b000,
    s_load = 3'b001,
    s_send = 3'b010,
    s_gap  = 3'b011,
    s_done = 3'b100
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [WORD_WIDTH-1:0] r_id;
  logic [WORD_WIDTH-1:0] r_hops;
  logic [WORD_WIDTH-1:0] r_q;
  logic [1:0]            r_word_idx;
  logic [15:0]           r_rep_cnt;
  logic [15:0]           r_gap_cnt;

  logic                  w_xfer;
  logic                  w_last_word;
  logic                  w_more;
  logic [WORD_WIDTH-1:0] w_hops_next;
  logic [WORD_WIDTH-1:0] w_word;

  assign w_xfer      = (r_state == s_send) && tx_ready;
  assign w_last_word = (r_word_idx == 2'd3);
  assign w_more      = (({1'b0, r_rep_cnt} + 17'd1) < C_REPS);

  // Relay hop count saturates rather than wrapping back to "I am the CH".
  assign w_hops_next = role_CH      ? '0 :
                       (&hopsFromCH) ? hopsFromCH : (hopsFromCH + C_ONE);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= s_idle;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (HB_reset) begin
      w_next = s_idle;
    end else begin
      case (r_state)
        s_idle: if (en_CHadv) w_next = s_load;
        s_load: w_next = s_send;
        s_send: if (w_xfer && w_last_word) w_next = w_more ? s_gap : s_done;
        s_gap:  if (r_gap_cnt <= 16'd1) w_next = s_send;
        s_done: w_next = s_idle;
        default: w_next = s_idle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_id       <= '0;
      r_hops     <= '0;
      r_q        <= '0;
      r_word_idx <= 2'd0;
      r_rep_cnt  <= 16'd0;
      r_gap_cnt  <= 16'd0;
    end else if (HB_reset) begin
      r_word_idx <= 2'd0;
      r_rep_cnt  <= 16'd0;
      r_gap_cnt  <= 16'd0;
    end else begin
      case (r_state)
        s_load: begin
          r_id       <= myNodeID;
          r_q        <= myQValue;
          r_hops     <= w_hops_next;
          r_word_idx <= 2'd0;
          r_rep_cnt  <= 16'd0;
        end
        s_send: begin
          if (w_xfer) begin
            // 2-bit index wraps to 0 after word 3, ready for the next repeat.
            r_word_idx <= r_word_idx + 2'd1;
            if (w_last_word) begin
              r_rep_cnt <= r_rep_cnt + 16'd1;
              if (w_more) r_gap_cnt <= ADV_INTERVAL;
            end
          end
        end
        s_gap: begin
          if (r_gap_cnt != 16'd0) r_gap_cnt <= r_gap_cnt - 16'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_word = MSG_TYPE_CH;
    case (r_word_idx)
      2'd0: w_word = MSG_TYPE_CH;
      2'd1: w_word = r_id;
      2'd2: w_word = r_hops;
      2'd3: w_word = r_q;
      default: w_word = MSG_TYPE_CH;
    endcase
  end

  assign tx_valid = (r_state == s_send);
  assign tx_data  = tx_valid ? w_word : '0;
  assign tx_busy  = (r_state != s_idle);
  assign adv_done = (r_state == s_done);

endmodule
`default_nettype wire

// File: tb/tb_ch_advert_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ch_advert_tx
// Purpose  : Scoreboard bench for ch_advert_tx: expected words are queued
//            when a round is started and popped as the DUT transfers them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ch_advert_tx;

  logic        clk = 1'b0;
  logic        nrst;
  logic        en_CHadv;
  logic        HB_reset;
  logic        role_CH;
  logic [15:0] myNodeID;
  logic [15:0] myQValue;
  logic [15:0] hopsFromCH;
  logic        tx_ready;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_busy;
  logic        adv_done;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_count;
  int          done_edge;
  logic [15:0] exp_q[$];
  int          xfer_edges[$];

  ch_advert_tx dut (
    .clk(clk), .nrst(nrst), .en_CHadv(en_CHadv), .HB_reset(HB_reset),
    .role_CH(role_CH), .myNodeID(myNodeID), .myQValue(myQValue),
    .hopsFromCH(hopsFromCH), .tx_ready(tx_ready), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_busy(tx_busy), .adv_done(adv_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inputs only change just after a rising edge, so what is seen here is
  // exactly what the next rising edge will sample.
  always @(negedge clk) begin
    if (nrst) begin
      if (adv_done) begin
        done_count = done_count + 1;
        done_edge  = cyc;
      end
      if (tx_valid && tx_ready) begin
        xfer_edges.push_back(cyc + 1);
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL word_unexpected: got %h, required no transfer", tx_data);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            errors = errors + 1;
            $display("FAIL word: got %h, required %h (edge %0d)", tx_data, e, cyc + 1);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_track();
    exp_q.delete();
    xfer_edges.delete();
    done_count = 0;
    done_edge  = -1;
  endtask

  task automatic push_round(input logic [15:0] id, input logic [15:0] hops,
                            input logic [15:0] q, input int reps);
    for (int r = 0; r < reps; r++) begin
      exp_q.push_back(16'h0001);
      exp_q.push_back(id);
      exp_q.push_back(hops);
      exp_q.push_back(q);
    end
  endtask

  task automatic start_round(output int e0);
    en_CHadv = 1'b1;
    tick();
    e0 = cyc;
    en_CHadv = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while (tx_busy && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (tx_busy) begin
      errors++;
      $display("FAIL %s_timeout: tx_busy=%b after %0d cycles, required 0", name, tx_busy, limit);
    end
  endtask

  task automatic check_common(input string name, input int words, input int dones);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover: %0d words untransferred, required 0", name, exp_q.size());
    end
    checks++;
    if (xfer_edges.size() != words) begin
      errors++;
      $display("FAIL %s_count: %0d transfers, required %0d", name, xfer_edges.size(), words);
    end
    checks++;
    if (done_count != dones) begin
      errors++;
      $display("FAIL %s_done_count: %0d, required %0d", name, done_count, dones);
    end
  endtask

  task automatic test_reset();
    int e0;
    nrst = 1'b0;
    #1;
    checks++;
    if ({tx_valid, tx_data, tx_busy, adv_done} !== 19'd0) begin
      errors++;
      $display("FAIL reset_init: v=%b d=%h b=%b done=%b, required all 0", tx_valid, tx_data, tx_busy, adv_done);
    end
    tick(); tick();
    nrst = 1'b1;
    tick();
    clear_track();
    role_CH = 1'b1; myNodeID = 16'h0005; myQValue = 16'h0100;
    push_round(16'h0005, 16'h0000, 16'h0100, 3);
    start_round(e0);
    while (cyc < e0 + 3) tick();
    #2 nrst = 1'b0;
    #1;
    checks++;
    if ({tx_valid, tx_data, tx_busy, adv_done} !== 19'd0) begin
      errors++;
      $display("FAIL reset_mid: v=%b d=%h b=%b done=%b, required all 0", tx_valid, tx_data, tx_busy, adv_done);
    end
    tick();
    nrst = 1'b1;
    tick();
    clear_track();
    push_round(16'h0005, 16'h0000, 16'h0100, 3);
    start_round(e0);
    wait_idle("reset_fresh", 200);
    check_common("reset_fresh", 12, 1);
  endtask

  task automatic test_ch_round();
    int e0;
    clear_track();
    role_CH = 1'b1; myNodeID = 16'h0005; myQValue = 16'h0100;
    push_round(16'h0005, 16'h0000, 16'h0100, 3);
    start_round(e0);
    wait_idle("ch", 200);
    check_common("ch", 12, 1);
    if (xfer_edges.size() == 12) begin
      checks++;
      if (xfer_edges[0] != e0 + 2) begin
        errors++;
        $display("FAIL ch_first_edge: E%0d, required E%0d", xfer_edges[0] - e0, 2);
      end
      checks++;
      if (xfer_edges[4] != e0 + 26) begin
        errors++;
        $display("FAIL ch_gap: repeat 2 at E%0d, required E%0d", xfer_edges[4] - e0, 26);
      end
      checks++;
      if (xfer_edges[11] != e0 + 53) begin
        errors++;
        $display("FAIL ch_last_edge: E%0d, required E%0d", xfer_edges[11] - e0, 53);
      end
    end
    checks++;
    if (done_edge != e0 + 53) begin
      errors++;
      $display("FAIL ch_done_edge: E%0d, required E%0d", done_edge - e0, 53);
    end
  endtask

  task automatic test_relay_hops();
    int e0;
    clear_track();
    role_CH = 1'b0; hopsFromCH = 16'h0002;
    myNodeID = 16'h0007; myQValue = 16'h0042;
    push_round(16'h0007, 16'h0003, 16'h0042, 3);
    start_round(e0);
    wait_idle("relay2", 200);
    check_common("relay2", 12, 1);
    clear_track();
    hopsFromCH = 16'hffff;
    push_round(16'h0007, 16'hffff, 16'h0042, 3);
    start_round(e0);
    wait_idle("relay_sat", 200);
    check_common("relay_sat", 12, 1);
    role_CH = 1'b1;
  endtask

  task automatic test_backpressure();
    int e0;
    clear_track();
    role_CH = 1'b0; hopsFromCH = 16'h0004;
    myNodeID = 16'h0005; myQValue = 16'h0100;
    push_round(16'h0005, 16'h0005, 16'h0100, 3);
    start_round(e0);
    while (cyc < e0 + 3) tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 16'h0005) begin
        errors++;
        $display("FAIL bp_hold: v=%b d=%h, required v=1 d=0005", tx_valid, tx_data);
      end
      tick();
    end
    tx_ready = 1'b1;
    wait_idle("bp", 200);
    check_common("bp", 12, 1);
    checks++;
    if (done_edge != e0 + 56) begin
      errors++;
      $display("FAIL bp_done_edge: E%0d, required E%0d", done_edge - e0, 56);
    end
    role_CH = 1'b1;
  endtask

  task automatic test_abort();
    int e0;
    clear_track();
    role_CH = 1'b1; myNodeID = 16'h0005; myQValue = 16'h0100;
    push_round(16'h0005, 16'h0000, 16'h0100, 1);
    start_round(e0);
    while (cyc < e0 + 10) tick();
    HB_reset = 1'b1;
    tick();
    HB_reset = 1'b0;
    checks++;
    if (tx_busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b valid=%b, required 0 0", tx_busy, tx_valid);
    end
    for (int i = 0; i < 80; i++) tick();
    check_common("abort", 4, 0);
  endtask

  task automatic test_latch_ignore();
    int e0;
    clear_track();
    role_CH = 1'b1; myNodeID = 16'h0005; myQValue = 16'h0100;
    push_round(16'h0005, 16'h0000, 16'h0100, 3);
    start_round(e0);
    while (cyc < e0 + 3) tick();
    myNodeID = 16'h0009;
    en_CHadv = 1'b1;
    tick();
    en_CHadv = 1'b0;
    while (cyc < e0 + 30) tick();
    en_CHadv = 1'b1;
    tick();
    en_CHadv = 1'b0;
    wait_idle("latch", 200);
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL latch_requeue: busy=%b, required 0", tx_busy);
    end
    check_common("latch", 12, 1);
    myNodeID = 16'h0005;
  endtask

  task automatic test_simultaneous();
    int e0;
    clear_track();
    en_CHadv = 1'b1; HB_reset = 1'b1;
    tick();
    en_CHadv = 1'b0; HB_reset = 1'b0;
    checks++;
    if (tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL simul_idle: busy=%b, required 0", tx_busy);
    end
    push_round(16'h0005, 16'h0000, 16'h0100, 3);
    start_round(e0);
    while (cyc < e0 + 52) tick();
    HB_reset = 1'b1;
    tick();
    HB_reset = 1'b0;
    checks++;
    if (tx_busy !== 1'b0 || adv_done !== 1'b0) begin
      errors++;
      $display("FAIL simul_final: busy=%b done=%b, required 0 0", tx_busy, adv_done);
    end
    for (int i = 0; i < 5; i++) tick();
    check_common("simul_final", 12, 0);
  endtask

  initial begin
    nrst = 1'b0; en_CHadv = 1'b0; HB_reset = 1'b0; role_CH = 1'b1;
    myNodeID = 16'h0005; myQValue = 16'h0100; hopsFromCH = 16'h0000;
    tx_ready = 1'b1;
    done_count = 0; done_edge = -1;
    test_reset();
    test_ch_round();
    test_relay_hops();
    test_backpressure();
    test_abort();
    test_latch_ignore();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ch_advert_tx.md
# ch_advert_tx

Cluster-head advertisement transmitter. It is the sending end of the CH-advertisement message that member nodes parse into (CH ID, hops, Q-value) candidates. When triggered, it latches the node's identity, hop count and Q-value, then serializes a 4-word advertisement onto a valid/ready word stream toward the radio packet layer. The message is repeated a fixed number of times with an idle gap between repeats, so that late-listening neighbours still receive it. It sits beside the CH-selection logic in every node: CH nodes originate advertisements, member nodes relay them with the hop count incremented.

## Interface
- WORD_WIDTH, 16, width of every data word
- MSG_TYPE_CH, 16'h0001, header word identifying a CH advertisement
- ADV_INTERVAL, 16'd20, idle cycles between repeats; minimum 1
- ADV_REPEATS, 16'd3, transmissions per round; a value of 0 is treated as 1

- clk  in  1  system clock, rising edge
- nrst  in  1  asynchronous active-low reset
- en_CHadv  in  1  start an advertisement round; sampled only in s_idle
- HB_reset  in  1  reclustering abort; highest priority
- role_CH  in  1  1 = node is CH (hops field 0), 0 = relay (hops = hopsFromCH+1)
- myNodeID  in  WORD_WIDTH  own node ID
- myQValue  in  WORD_WIDTH  own Q-value
- hopsFromCH  in  WORD_WIDTH  hops to chosen CH (relay mode only)
- tx_ready  in  1  downstream accepts tx_data this cycle
- tx_valid  out  1  tx_data holds a valid word
- tx_data  out  WORD_WIDTH  advertisement word
- tx_busy  out  1  round in progress (state != s_idle)
- adv_done  out  1  one-cycle pulse when a round completes normally

## Operation
- States:
  - s_idle 3'b000
  - s_load 3'b001
  - s_send 3'b010
  - s_gap 3'b011
  - s_done 3'b100
- s_idle:
  - en_CHadv=1 → s_load.
  - en_CHadv while busy is ignored; it is neither queued nor restarting.
- s_load:
  - Latch ID_r=myNodeID and Q_r=myQValue.
  - Latch hops_r: 0 if role_CH=1; otherwise hopsFromCH+1, saturating (hopsFromCH=16'hffff gives 16'hffff).
  - Clear word_idx and rep_cnt. Go to s_send.
- s_send:
  - Word order: word_idx 0 = MSG_TYPE_CH, 1 = ID_r, 2 = hops_r, 3 = Q_r.
  - A word transfers on a rising edge with tx_valid&tx_ready; word_idx then increments.
  - After word 3 transfers, rep_cnt increments.
  - If rep_cnt+1 < max(ADV_REPEATS,1): go to s_gap, load gap_cnt=ADV_INTERVAL, reset word_idx to 0.
  - Otherwise go to s_done.
- s_gap: gap_cnt decrements each cycle; on the edge where gap_cnt==1 → s_send.
- s_done: adv_done=1 for that single cycle, then → s_idle.
- HB_reset=1 in any state:
  - Next state is s_idle; word_idx, rep_cnt and gap_cnt are cleared.
  - adv_done is not pulsed, and any partial message is abandoned.
- Latched fields do not change mid-round, regardless of input changes.
- tx_valid = (state==s_send). tx_data = selected word while tx_valid=1, else 0.

## Timing
- Reset values: state s_idle, tx_valid 0, tx_data 0, tx_busy 0, adv_done 0, latched fields 0.
- Latency with tx_ready held at 1:
  - en_CHadv sampled at edge E0 → s_load.
  - E1 → s_send; tx_valid is high after E1.
  - Words transfer at E2..E5.
- Round timing with tx_ready held at 1:
  - Each gap keeps tx_valid low for exactly ADV_INTERVAL cycles.
  - Each round takes 4+ADV_INTERVAL cycles, except the last.
  - With defaults, the last transfer is at E53, adv_done is high E53–E54, and s_idle is reached at E54.
- Backpressure:
  - While tx_ready=0, tx_valid stays 1 and tx_data is stable.
  - No timeout; the block waits indefinitely.
- Simultaneous events:
  - HB_reset together with en_CHadv in s_idle → stay in s_idle.
  - HB_reset on the same edge as the final transfer → s_idle, no adv_done.
- Reset mid-operation: immediate return to the reset values above.

## Test plan
1. Reset:
   - Assert nrst=0 mid-round.
   - Required: tx_valid=0, tx_data=0, tx_busy=0 and adv_done=0 immediately; en_CHadv after release starts a fresh round.
2. CH round:
   - Stimulus: role_CH=1, myNodeID=16'h0005, myQValue=16'h0100, tx_ready=1, en_CHadv pulse at E0.
   - Required: words 0001, 0005, 0000, 0100 at E2..E5, repeated 3 times with 20-cycle gaps; adv_done exactly at E53.
3. Relay hops:
   - role_CH=0, hopsFromCH=2 → hops word 0003.
   - hopsFromCH=16'hffff → hops word ffff.
4. Backpressure:
   - Stimulus: hold tx_ready=0 for 3 cycles while word 2 is presented.
   - Required: tx_data stays at the hops word with tx_valid=1; the sequence resumes without loss or duplication; the round completes 3 cycles late.
5. Abort:
   - Stimulus: HB_reset pulse during the first s_gap.
   - Required: s_idle next cycle, tx_busy=0, no further words, no adv_done.
6. Latch/ignore:
   - Stimulus: change myNodeID to 16'h0009 and pulse en_CHadv during round 1.
   - Required: all 3 repeats still carry 0005, and exactly one adv_done.
